// File: rtl/uart_game_tx.sv
// uart_game_tx: 8N1 UART sender for 3-byte START/SCORE game-link frames
module uart_game_tx #(
  parameter int         CLKS_PER_BIT = 651,
  parameter logic [7:0] HDR_START    = 8'hA5,
  parameter logic [7:0] HDR_SCORE    = 8'h5A
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       send_start,
  input  logic       send_score,
  input  logic [6:0] score,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] hdr, pay, cur, sh;
  logic pend_start, pend_score, is_start, tick;
  logic [6:0] pend_val;
  // current frame byte (checksum derived from the latched header/payload) and bit-period end
  always_comb begin
    cur  = byte_cnt == 2'd0 ? hdr : byte_cnt == 2'd1 ? pay : hdr ^ pay;
    tick = cnt == LAST;
  end
  // frame sequencer, request latching and registered serial outputs
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      hdr        <= '0;
      pay        <= '0;
      sh         <= '0;
      pend_start <= 1'b0;
      pend_score <= 1'b0;
      pend_val   <= '0;
      is_start   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= tick ? '0 : cnt + 1'b1;
      if (state != IDLE) begin
        if (send_start && !is_start) pend_start <= 1'b1;
        if (send_score) begin
          pend_score <= 1'b1;
          pend_val   <= score;
        end
      end
      case (state)
        IDLE: begin
          cnt      <= '0;
          byte_cnt <= '0;
          if (pend_start || send_start) begin
            hdr        <= HDR_START;
            pay        <= 8'h00;
            is_start   <= 1'b1;
            pend_start <= 1'b0;
            state      <= START_BIT;
            tx         <= 1'b0;
            busy       <= 1'b1;
            if (send_score) begin
              pend_score <= 1'b1;
              pend_val   <= score;
            end
          end else if (pend_score || send_score) begin
            hdr        <= HDR_SCORE;
            pay        <= {1'b0, send_score ? score : pend_val};
            is_start   <= 1'b0;
            pend_score <= 1'b0;
            state      <= START_BIT;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START_BIT: if (tick) begin
          state   <= DATA;
          sh      <= cur;
          tx      <= cur[0];
          bit_cnt <= '0;
        end
        DATA: if (tick) begin
          sh      <= {1'b0, sh[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
          state   <= bit_cnt == 3'd7 ? STOP_BIT : DATA;
          tx      <= bit_cnt == 3'd7 ? 1'b1 : sh[1];
        end
        STOP_BIT: if (tick) begin
          if (byte_cnt == 2'd2) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            state    <= START_BIT;
            tx       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_game_tx.sv
// tb_uart_game_tx: scoreboard bench decoding the UART line against queued expected bytes
module tb_uart_game_tx;
  localparam int CPB = 4;
  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic send_start = 1'b0;
  logic send_score = 1'b0;
  logic [6:0] score = '0;
  logic tx, busy, done;
  logic prev_done = 1'b0;
  int passed = 0;
  int total = 0;
  int dones = 0;
  logic [7:0] exp_q[$];

  uart_game_tx #(.CLKS_PER_BIT(CPB)) dut (
    .pclk(pclk), .rst(rst_n), .send_start(send_start), .send_score(send_score),
    .score(score), .tx(tx), .busy(busy), .done(done)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  // UART decoder: samples each bit mid-period and checks against the scoreboard queue
  initial begin : mon
    logic [7:0] d;
    logic ok, sb;
    forever begin
      @(negedge pclk);
      if (rst_n && !tx) begin
        ok = 1'b1;
        repeat (CPB / 2) @(negedge pclk);
        sb = tx;
        ok = ok & rst_n;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge pclk);
          d[i] = tx;
          ok = ok & rst_n;
        end
        repeat (CPB) @(negedge pclk);
        ok = ok & rst_n;
        if (ok) begin
          chk("start_bit", sb, 0);
          chk("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_byte: got %0h, expected none", d);
          end else chk("rx_byte", d, exp_q.pop_front());
        end
      end
    end
  end

  // done pulse monitor: single-cycle and never while busy
  always @(negedge pclk) begin
    if (done) begin
      dones++;
      chk("done_busy_low", busy, 0);
      chk("done_width", prev_done, 0);
    end
    prev_done = done;
  end

  task automatic pulse(input logic s, input logic c, input logic [6:0] v);
    @(negedge pclk);
    send_start = s;
    send_score = c;
    score = v;
    @(negedge pclk);
    send_start = 1'b0;
    send_score = 1'b0;
    score = 7'h55;
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  task automatic finish_frame(input string name, input int want);
    int cyc = 1;
    while (cyc < 400) begin
      @(negedge pclk);
      if (!busy) break;
      cyc++;
    end
    chk({name, "_busy_cycles"}, cyc, want);
    chk({name, "_done"}, done, 1);
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (busy && c < 400) begin
      @(negedge pclk);
      c++;
    end
    chk({name, "_done"}, done, 1);
  endtask

  task automatic idle_for(input string name, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge pclk);
      if ({tx, busy, done} !== 3'b100) bad++;
    end
    chk(name, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) @(negedge pclk);
    chk("reset_outputs", {tx, busy, done}, 3'b100);
    rst_n = 1'b1;
    idle_for("idle_20", 20);

    push3(8'hA5, 8'h00, 8'hA5);
    d0 = dones;
    pulse(1'b1, 1'b0, 7'd0);
    chk("start_latency", {tx, busy}, 2'b01);
    finish_frame("start", 120);
    @(negedge pclk);
    chk("start_done_cleared", done, 0);
    repeat (10) @(negedge pclk);
    chk("start_bytes_drained", exp_q.size(), 0);
    chk("start_done_count", dones - d0, 1);

    push3(8'h5A, 8'h2A, 8'h70);
    d0 = dones;
    pulse(1'b0, 1'b1, 7'd42);
    chk("score_latency", {tx, busy}, 2'b01);
    finish_frame("score42", 120);
    repeat (10) @(negedge pclk);
    chk("score42_bytes_drained", exp_q.size(), 0);
    chk("score42_done_count", dones - d0, 1);

    push3(8'hA5, 8'h00, 8'hA5);
    push3(8'h5A, 8'h09, 8'h53);
    d0 = dones;
    pulse(1'b1, 1'b0, 7'd0);
    repeat (10) @(negedge pclk);
    pulse(1'b0, 1'b1, 7'd7);
    repeat (10) @(negedge pclk);
    pulse(1'b0, 1'b1, 7'd9);
    repeat (10) @(negedge pclk);
    pulse(1'b1, 1'b0, 7'd0);
    repeat (5) @(negedge pclk);
    pulse(1'b1, 1'b0, 7'd0);
    wait_done("coalesce_start");
    @(negedge pclk);
    chk("coalesce_restart", {tx, busy, done}, 3'b010);
    finish_frame("coalesce_score", 120);
    idle_for("coalesce_no_second_start", 60);
    chk("coalesce_bytes_drained", exp_q.size(), 0);
    chk("coalesce_done_count", dones - d0, 2);

    push3(8'hA5, 8'h00, 8'hA5);
    push3(8'h5A, 8'h03, 8'h59);
    d0 = dones;
    pulse(1'b1, 1'b1, 7'd3);
    chk("both_latency", {tx, busy}, 2'b01);
    finish_frame("both_start", 120);
    @(negedge pclk);
    chk("both_restart", {tx, busy, done}, 3'b010);
    finish_frame("both_score", 120);
    repeat (10) @(negedge pclk);
    chk("both_bytes_drained", exp_q.size(), 0);
    chk("both_done_count", dones - d0, 2);

    push3(8'h5A, 8'h05, 8'h5F);
    pulse(1'b0, 1'b1, 7'd5);
    repeat (10) @(negedge pclk);
    pulse(1'b1, 1'b0, 7'd0);
    repeat (37) @(negedge pclk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {tx, busy, done}, 3'b100);
    chk("abort_header_seen", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    idle_for("abort_no_pending", 60);
    push3(8'hA5, 8'h00, 8'hA5);
    pulse(1'b1, 1'b0, 7'd0);
    chk("post_reset_latency", {tx, busy}, 2'b01);
    finish_frame("post_reset", 120);
    repeat (10) @(negedge pclk);
    chk("post_reset_bytes_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
